// File: rtl/reaction_pkg.sv
// -----------------------------------------------------------------------------
// reaction_pkg
// Shared definitions for the reaction game: round controller state encoding,
// winner codes exchanged with the score tracker, and the hold-off LFSR
// constants and step function.
// -----------------------------------------------------------------------------
package reaction_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_COUNTDOWN,
      ST_DELAY,
      ST_REACT,
      ST_RESULT,
      ST_MATCH_END
   } state_e;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

   // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {cur[14:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Prescaler producing a one-cycle tick every TICK_CYCLES clocks. A restart
// pulse zeroes the count so the first tick lands TICK_CYCLES cycles later.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   restart     clear the prescaler (asserted on every state entry)
//   tick        one-cycle strobe
// -----------------------------------------------------------------------------
module tick_gen #(
   parameter int unsigned TICK_CYCLES = 100000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // tick is not gated by restart: the tick itself is what causes the state
   // change that raises restart in the same cycle.
   assign tick = (cnt_q == LAST);

   always_comb begin
      if (restart || tick) cnt_d = '0;
      else                 cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/round_sequencer.sv
// -----------------------------------------------------------------------------
// round_sequencer
// Round controller for the two-player reaction game: countdown, random
// hold-off, react window, result hold; counts round wins and ends the match
// at WIN_SCORE.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start_btn              single-cycle start / acknowledge pulse
//   switchP1, switchP2     player switches (both must be low to arm)
//   round_over, jump_start, winner   results from the score tracker
//   countdown_in_action, countdown_digit   countdown display
//   round_in_action        high in DELAY and REACT
//   delay_done, go_led     high in REACT
//   p1_wins, p2_wins       round wins this match
//   match_over, match_winner   match result
// All outputs are registered from the next-state decode.
// -----------------------------------------------------------------------------
module round_sequencer
   import reaction_pkg::*;
#(
   parameter int unsigned TICK_CYCLES   = 100000000,
   parameter int unsigned COUNT_FROM    = 3,
   parameter int unsigned DELAY_MIN     = 1,
   parameter int unsigned DELAY_MASK    = 3,
   parameter int unsigned REACT_TIMEOUT = 5,
   parameter int unsigned HOLD_TICKS    = 2,
   parameter int unsigned WIN_SCORE     = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_btn,
   input  logic       switchP1,
   input  logic       switchP2,
   input  logic       round_over,
   input  logic       jump_start,
   input  logic [1:0] winner,
   output logic       countdown_in_action,
   output logic [3:0] countdown_digit,
   output logic       round_in_action,
   output logic       delay_done,
   output logic       go_led,
   output logic [3:0] p1_wins,
   output logic [3:0] p2_wins,
   output logic       match_over,
   output logic [1:0] match_winner
);

   localparam logic [3:0] WIN_MAX    = 4'(WIN_SCORE);
   localparam logic [7:0] REACT_LAST = 8'(REACT_TIMEOUT - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(HOLD_TICKS - 1);

   state_e      state_q, state_d;
   logic        tick, state_entry, delay_expired;
   logic [15:0] lfsr_q;
   logic [7:0]  ticks_q, ticks_d;        // ticks seen since entering this state
   logic [8:0]  ticks_inc;
   logic [7:0]  delay_len_q, delay_len_d;
   logic [3:0]  digit_q, digit_d;
   logic [3:0]  p1_q, p1_d, p2_q, p2_d;
   logic        cd_q, cd_d, ria_q, ria_d, dd_q, dd_d, mo_q, mo_d;
   logic [1:0]  mw_q, mw_d;

   // The tracker already folds jump_start into winner for a false start.
   logic unused_inputs;
   assign unused_inputs = jump_start;

   assign state_entry   = (state_d != state_q);
   assign ticks_inc     = {1'b0, ticks_q} + 9'd1;
   assign delay_expired = tick && (ticks_inc >= {1'b0, delay_len_q});

   tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (state_entry),
      .tick    (tick)
   );

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Free-running; the seed is non-zero so the sequence never locks up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= LFSR_SEED;
      else        lfsr_q <= lfsr_next(lfsr_q);
   end

   // NOTE: every combinational output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:      if (start_btn) state_d = ST_ARM;
         ST_ARM:       if (!switchP1 && !switchP2) state_d = ST_COUNTDOWN;
         ST_COUNTDOWN: if (tick && digit_q == 4'd1) state_d = ST_DELAY;
         ST_DELAY: begin
            // round_over beats a simultaneous hold-off expiry: false start.
            if (round_over)         state_d = ST_RESULT;
            else if (delay_expired) state_d = ST_REACT;
         end
         ST_REACT: begin
            if (round_over || (tick && ticks_q == REACT_LAST)) state_d = ST_RESULT;
         end
         ST_RESULT: begin
            if (tick && ticks_q == HOLD_LAST)
               state_d = (p1_q == WIN_MAX || p2_q == WIN_MAX) ? ST_MATCH_END : ST_ARM;
         end
         ST_MATCH_END: if (start_btn) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ticks_d     = ticks_q;
      delay_len_d = delay_len_q;
      digit_d     = 4'd0;
      p1_d        = p1_q;
      p2_d        = p2_q;

      if (state_entry)                    ticks_d = 8'd0;
      else if (tick && ticks_q != 8'hFF)  ticks_d = ticks_q + 8'd1;

      if (state_entry && state_d == ST_DELAY)
         delay_len_d = 8'(DELAY_MIN) + (lfsr_q[7:0] & 8'(DELAY_MASK));

      if (state_d == ST_COUNTDOWN) begin
         if (state_entry) digit_d = 4'(COUNT_FROM);
         else if (tick)   digit_d = digit_q - 4'd1;
         else             digit_d = digit_q;
      end

      // Only a round_over-driven entry credits; a timeout entry does not.
      if (state_d == ST_IDLE) begin
         p1_d = 4'd0;
         p2_d = 4'd0;
      end else if (state_entry && state_d == ST_RESULT && round_over) begin
         if (winner == WIN_P1 && p1_q < WIN_MAX) p1_d = p1_q + 4'd1;
         if (winner == WIN_P2 && p2_q < WIN_MAX) p2_d = p2_q + 4'd1;
      end

      cd_d  = (state_d == ST_COUNTDOWN);
      ria_d = (state_d == ST_DELAY) || (state_d == ST_REACT);
      dd_d  = (state_d == ST_REACT);
      mo_d  = (state_d == ST_MATCH_END);
      mw_d  = WIN_NONE;
      if (state_d == ST_MATCH_END) begin
         if (p1_q == WIN_MAX)      mw_d = WIN_P1;
         else if (p2_q == WIN_MAX) mw_d = WIN_P2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ticks_q     <= 8'd0;
         delay_len_q <= 8'd0;
         digit_q     <= 4'd0;
         p1_q        <= 4'd0;
         p2_q        <= 4'd0;
         cd_q        <= 1'b0;
         ria_q       <= 1'b0;
         dd_q        <= 1'b0;
         mo_q        <= 1'b0;
         mw_q        <= WIN_NONE;
      end else begin
         ticks_q     <= ticks_d;
         delay_len_q <= delay_len_d;
         digit_q     <= digit_d;
         p1_q        <= p1_d;
         p2_q        <= p2_d;
         cd_q        <= cd_d;
         ria_q       <= ria_d;
         dd_q        <= dd_d;
         mo_q        <= mo_d;
         mw_q        <= mw_d;
      end
   end

   assign countdown_in_action = cd_q;
   assign countdown_digit     = digit_q;
   assign round_in_action     = ria_q;
   assign delay_done          = dd_q;
   assign go_led              = dd_q;
   assign p1_wins             = p1_q;
   assign p2_wins             = p2_q;
   assign match_over          = mo_q;
   assign match_winner        = mw_q;

endmodule

// File: tb/tb_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_round_sequencer
// Randomised rounds checked against a round-level reference: expected
// countdown spacing, hold-off length from a free-running LFSR model, react
// window length, result hold, and win/match bookkeeping.
// -----------------------------------------------------------------------------
module tb_round_sequencer;

   localparam int TICK  = 4;
   localparam int CNT   = 3;
   localparam int DMIN  = 1;
   localparam int DMASK = 3;
   localparam int RTO   = 5;
   localparam int HOLD  = 2;
   localparam int WIN   = 2;

   localparam int M_LEGAL = 0, M_FALSE = 1, M_TIMEOUT = 2;
   localparam int S_CD = 0, S_DD = 1, S_MO = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_btn = 1'b0, switchP1 = 1'b0, switchP2 = 1'b0;
   logic       round_over = 1'b0, jump_start = 1'b0;
   logic [1:0] winner = 2'b00;
   logic       countdown_in_action, round_in_action, delay_done, go_led, match_over;
   logic [3:0] countdown_digit, p1_wins, p2_wins;
   logic [1:0] match_winner;

   int total = 0;
   int bad   = 0;
   int p1m   = 0;
   int p2m   = 0;

   logic [15:0] lfsr_m, lfsr_prev;

   round_sequencer #(
      .TICK_CYCLES(TICK), .COUNT_FROM(CNT), .DELAY_MIN(DMIN), .DELAY_MASK(DMASK),
      .REACT_TIMEOUT(RTO), .HOLD_TICKS(HOLD), .WIN_SCORE(WIN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_btn(start_btn),
      .switchP1(switchP1), .switchP2(switchP2),
      .round_over(round_over), .jump_start(jump_start), .winner(winner),
      .countdown_in_action(countdown_in_action), .countdown_digit(countdown_digit),
      .round_in_action(round_in_action), .delay_done(delay_done), .go_led(go_led),
      .p1_wins(p1_wins), .p2_wins(p2_wins),
      .match_over(match_over), .match_winner(match_winner)
   );

   always #5 clk = ~clk;

   // Reference LFSR: x^16+x^14+x^13+x^11, advancing once per clock.
   // lfsr_prev is the value that was current just before the latest edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_m    <= 16'hACE1;
         lfsr_prev <= 16'hACE1;
      end else begin
         lfsr_prev <= lfsr_m;
         lfsr_m    <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int k);
      repeat (k) @(negedge clk);
   endtask

   function automatic logic sig(input int which);
      case (which)
         S_CD:    return countdown_in_action;
         S_DD:    return delay_done;
         S_MO:    return match_over;
         default: return round_in_action;
      endcase
   endfunction

   task automatic wait_level(input string tag, input int which, input int budget, output int n);
      n = 0;
      while (sig(which) !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sig(which) !== 1'b1) check(tag, {31'b0, sig(which)}, 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_cd"},   countdown_in_action, 0);
      check({tag, "_dig"},  countdown_digit, 0);
      check({tag, "_ria"},  round_in_action, 0);
      check({tag, "_dd"},   delay_done, 0);
      check({tag, "_go"},   go_led, 0);
      check({tag, "_p1"},   p1_wins, 0);
      check({tag, "_p2"},   p2_wins, 0);
      check({tag, "_mo"},   match_over, 0);
      check({tag, "_mw"},   match_winner, 0);
   endtask

   // Press start from IDLE; optionally hold a switch high to stall ARM.
   task automatic start_match(input int hold);
      int n;
      switchP1 = (hold > 0);
      switchP2 = (hold > 0) && ($urandom_range(0, 1) == 1);
      start_btn = 1'b1;
      step(1);
      start_btn = 1'b0;
      if (hold > 0) begin
         step(hold);
         check("arm_hold", countdown_in_action, 0);
         switchP1 = 1'b0;
         switchP2 = 1'b0;
      end
      wait_level("arm_wait", S_CD, 20, n);
      check("arm_latency", n, 1);
   endtask

   // Called at the first sample of COUNTDOWN; returns at the next COUNTDOWN
   // start (done=0) or at MATCH_END (done=1).
   task automatic play_round(input int mode, input logic [1:0] w, input bit noise,
                             output bit done);
      int hold, k, n;
      logic [15:0] lat;
      bit credit, seen;

      // Countdown; stray start_btn / round_over here must be ignored.
      check("cd_first", countdown_digit, CNT);
      start_btn  = noise;
      round_over = noise;
      winner     = noise ? 2'b01 : 2'b00;
      step(1);
      start_btn = 1'b0;
      step(TICK - 1);
      for (int d = CNT - 1; d >= 1; d--) begin
         check("cd_digit", countdown_digit, d);
         if (d > 1) step(TICK);
      end
      step(TICK - 1);
      check("cd_before_delay", round_in_action, 0);
      round_over = 1'b0;
      winner     = 2'b00;
      step(1);
      check("delay_ria", round_in_action, 1);
      check("delay_cd_off", countdown_in_action, 0);
      check("delay_digit", countdown_digit, 0);

      lat  = lfsr_prev;
      hold = TICK * (DMIN + (int'(lat[7:0]) & DMASK));
      credit = 1'b0;

      if (mode == M_FALSE) begin
         k = ($urandom_range(0, 1) == 1) ? hold - 1 : $urandom_range(0, hold - 1);
         step(k);
         check("fs_no_go", go_led, 0);
         round_over = 1'b1;
         jump_start = 1'b1;
         winner     = w;
         step(1);
         credit = 1'b1;
      end else begin
         wait_level("react_wait", S_DD, hold + 8, n);
         check("holdoff_len", n, hold);
         check("react_go", go_led, 1);
         check("react_ria", round_in_action, 1);
         if (mode == M_LEGAL) begin
            k = ($urandom_range(0, 2) == 0) ? TICK * RTO - 1 : $urandom_range(0, TICK * RTO - 1);
            step(k);
            check("react_open", delay_done, 1);
            round_over = 1'b1;
            winner     = w;
            step(1);
            credit = 1'b1;
         end else begin
            step(TICK * RTO - 1);
            check("timeout_last", delay_done, 1);
            step(1);
         end
      end
      round_over = 1'b0;
      jump_start = 1'b0;
      winner     = 2'b00;

      // RESULT entry.
      check("res_ria", round_in_action, 0);
      check("res_dd", delay_done, 0);
      if (credit) begin
         if (w == 2'b01 && p1m < WIN) p1m++;
         if (w == 2'b10 && p2m < WIN) p2m++;
      end
      check("res_p1", p1_wins, p1m);
      check("res_p2", p2_wins, p2m);

      seen = 1'b0;
      for (int i = 0; i < TICK * HOLD; i++) begin
         seen |= delay_done | go_led | round_in_action | countdown_in_action | match_over;
         step(1);
      end
      check("res_quiet", seen, 0);

      done = (p1m == WIN) || (p2m == WIN);
      if (done) begin
         check("match_over", match_over, 1);
         check("match_winner", match_winner, (p1m == WIN) ? 2'b01 : 2'b10);
      end else begin
         check("rearm_arm", countdown_in_action, 0);
         step(1);
         check("rearm_cd", countdown_in_action, 1);
      end
   endtask

   task automatic end_match();
      start_btn = 1'b1;
      step(1);
      start_btn = 1'b0;
      p1m = 0;
      p2m = 0;
      check("idle_p1", p1_wins, p1m);
      check("idle_p2", p2_wins, p2m);
      check("idle_mo", match_over, 0);
      check("idle_mw", match_winner, 0);
   endtask

   initial begin
      bit done;
      int rounds;

      // Reset state.
      step(3);
      check_all_zero("reset");
      rst_n = 1'b1;
      step(3);
      check_all_zero("idle");

      // Match 1: arming stall, fixed coverage rounds, then random rounds.
      start_match($urandom_range(3, 9));
      play_round(M_LEGAL,   2'b01, 1'b0, done);
      play_round(M_FALSE,   2'b10, 1'b1, done);
      play_round(M_TIMEOUT, 2'b00, 1'b0, done);
      play_round(M_LEGAL,   2'b11, 1'b0, done);
      rounds = 0;
      while (!done && rounds < 10) begin
         play_round($urandom_range(0, 2), 2'($urandom_range(1, 2)), 1'($urandom_range(0, 1)), done);
         rounds++;
      end
      if (!done) play_round(M_LEGAL, 2'b01, 1'b0, done);
      end_match();

      // Match 2: two P2 wins.
      start_match(0);
      done = 1'b0;
      while (!done) play_round(($urandom_range(0, 1) == 1) ? M_LEGAL : M_FALSE, 2'b10, 1'b0, done);
      check("m2_winner", match_winner, 2'b10);
      end_match();

      // Match 3: reset in the middle of a countdown with a non-zero score.
      start_match(0);
      play_round(M_LEGAL, 2'b01, 1'b0, done);
      step(TICK + 1);
      rst_n = 1'b0;
      #1;
      p1m = 0;
      p2m = 0;
      check_all_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      step(3);
      check("post_rst_cd", countdown_in_action, 0);
      start_match(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
